vga_frame_rd_sched: RTL and testbench
=====================================

// Module: vga_frame_rd_sched
// PURPOSE
//  Read scheduler between the DDR3 read port arbiter and the VGA pixel FIFO.
//  Each frame, issues word-addressed read bursts from the selected frame buffer (double-buffered).
//  Bursts are paced so the FIFO feeding the VGA timing generator's pix_data_req never overflows.
//  One outstanding burst at a time; flags FIFO underflow seen by the display side.
// PARAMETERS
//  H_ACTIVE    640        active pixels per line (one 16-bit word per pixel)
//  V_ACTIVE    480        active lines per frame
//  BURST_LEN   64         max words per read burst (1..255)
//  FIFO_DEPTH  1024       pixel FIFO depth in words
//  ADDR_W      28         DDR word address width
//  BASE0       28'h000000 frame buffer 0 base word address
//  BASE1       28'h080000 frame buffer 1 base word address
// PORTS
//  vga_clk      in   1       single clock for the whole block
//  sys_rst      in   1       reset, synchronous, active-high
//  frame_start  in   1       1-cycle pulse at start of vertical blanking
//  frame_sel    in   1       buffer select, sampled only on accepted frame_start
//  fifo_wr_cnt  in   11      current pixel FIFO fill level in words
//  fifo_empty   in   1       pixel FIFO empty
//  pix_data_req in   1       display is popping a pixel this cycle
//  fifo_clr     out  1       1-cycle FIFO flush pulse
//  rd_req       out  1       burst request to arbiter
//  rd_addr      out  ADDR_W  burst start word address
//  rd_len       out  8       burst length in words
//  rd_ack       in   1       arbiter accepted request (addr/len captured)
//  rd_done      in   1       1-cycle pulse: last word of burst written to FIFO
//  busy         out  1       frame fetch in progress (state not IDLE/DONE)
//  underflow    out  1       sticky: pix_data_req && fifo_empty seen this frame
// BEHAVIOUR
//  Reset: state IDLE; rd_req=0, rd_addr=0, rd_len=0, fifo_clr=0, busy=0, underflow=0.
//  Outputs are registered. words_left is a 19-bit counter, reset to H_ACTIVE*V_ACTIVE per frame.
//  States: IDLE, FLUSH, WAIT_ROOM, REQ, XFER, DONE.
//  IDLE/DONE: on frame_start -> FLUSH.
//    On that edge: latch base from frame_sel into rd_addr; words_left <= H_ACTIVE*V_ACTIVE.
//  FLUSH: fifo_clr=1 for exactly this cycle; clear underflow; -> WAIT_ROOM.
//    Timing: frame_start at edge N -> fifo_clr high in N+1.
//  WAIT_ROOM: when fifo_wr_cnt <= FIFO_DEPTH-BURST_LEN -> REQ.
//    On that edge: rd_len <= min(BURST_LEN, words_left); rd_req <= 1.
//    Earliest rd_req is edge N+3 after frame_start.
//  REQ: hold rd_req, rd_addr and rd_len stable until rd_ack.
//    On the rd_ack edge: rd_req <= 0; -> XFER.
//  XFER: wait for rd_done. On rd_done:
//    rd_addr += rd_len, modulo 2^ADDR_W (wraps silently).
//    words_left -= rd_len.
//    Next state: DONE if words_left == rd_len, else WAIT_ROOM.
//  Frame size need not be a multiple of BURST_LEN; the last burst carries the remainder.
//  frame_start mid-frame:
//    In WAIT_ROOM or REQ without rd_ack the same cycle: abort, drop rd_req, -> FLUSH (restart).
//    In REQ with rd_ack the same cycle: ack wins; enter XFER with restart pending.
//    In XFER: the bus burst cannot be aborted. Set restart_pend; on rd_done go to FLUSH.
//      rd_addr/words_left/frame_sel use the values captured at the frame_start pulse.
//    In FLUSH: ignored.
//  rd_ack while not in REQ, and rd_done while not in XFER: ignored.
//  underflow: set on any cycle with pix_data_req && fifo_empty; cleared only in FLUSH or by reset.
//  sys_rst at any time: immediate return to reset values.
//    The arbiter is reset by the same sys_rst, so no outstanding burst is tracked.
// STRUCTURE
//  Shared package vga_pkg: state localparams, H_ACTIVE/V_ACTIVE, FRAME_WORDS = H_ACTIVE*V_ACTIVE.
//    The same timing constants are used by the VGA timing generator.
//  Single module; no sub-module. The underflow/sticky logic stays inline.
// TESTING
//  1. Reset: hold sys_rst 3 cycles -> all outputs 0, state IDLE. No rd_req even with fifo_wr_cnt=0.
//  2. Full frame, defaults, frame_sel=0, rd_ack 2 cycles after rd_req, rd_done 70 cycles later,
//     FIFO model drains 1 word/4 cycles ->
//       exactly 4800 bursts, rd_len=64, addresses 0,64,...,306,9*... ending at 0x4AFC0;
//       busy falls after burst 4800; no underflow.
//  3. H_ACTIVE=100, V_ACTIVE=1 -> two bursts: (addr 0, len 64) then (addr 64, len 36); then DONE.
//  4. fifo_wr_cnt held at 961 -> no rd_req. Drop to 960 -> rd_req on the next edge.
//  5. frame_start with frame_sel=1 during XFER -> no fifo_clr until rd_done.
//     Then fifo_clr 1 cycle; next rd_addr=0x080000.
//  6. pix_data_req=1 with fifo_empty=1 for 1 cycle -> underflow=1 and stays 1.
//     Next frame_start -> underflow=0 during the cycle after the FLUSH cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA display constants and frame-read scheduler state encoding.
// Latency: none (declarations only).
// Backpressure: n/a. Contents: active-area timing constants, frame size in
// words, scheduler state enum. The VGA timing generator uses the same constants.
package vga_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;

  // Word counter width; must hold FRAME_WORDS.
  localparam int WORDS_W     = 19;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_WAIT_ROOM = 3'd2,
    ST_REQ       = 3'd3,
    ST_XFER      = 3'd4,
    ST_DONE      = 3'd5
  } rd_state_e;

endpackage

// File: rtl/vga_frame_rd_sched.sv
// DDR3 read-burst scheduler filling the VGA pixel FIFO from a double-buffered frame.
// Latency: frame_start -> fifo_clr 1 cycle, earliest rd_req 3 cycles; all outputs registered.
// Backpressure: holds rd_req/rd_addr/rd_len until rd_ack; no new burst until FIFO has a burst of room.
// Ports: vga_clk/sys_rst (sync, active-high); frame_start/frame_sel from timing;
//   fifo_wr_cnt/fifo_empty/pix_data_req from FIFO side; fifo_clr flush pulse;
//   rd_req/rd_addr/rd_len/rd_ack/rd_done arbiter handshake; busy and sticky underflow status.
module vga_frame_rd_sched #(
  parameter int                H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int                V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int                BURST_LEN  = 64,
  parameter int                FIFO_DEPTH = 1024,
  parameter int                ADDR_W     = 28,
  parameter logic [ADDR_W-1:0] BASE0      = '0,
  parameter logic [ADDR_W-1:0] BASE1      = ADDR_W'(32'h0008_0000)
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              frame_start,
  input  logic              frame_sel,
  input  logic [10:0]       fifo_wr_cnt,
  input  logic              fifo_empty,
  input  logic              pix_data_req,
  output logic              fifo_clr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              busy,
  output logic              underflow
);
  import vga_pkg::*;

  localparam logic [WORDS_W-1:0] FRAME_W  = WORDS_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [WORDS_W-1:0] BURST_W  = WORDS_W'(BURST_LEN);
  localparam logic [10:0]        ROOM_LVL = 11'(FIFO_DEPTH - BURST_LEN);

  rd_state_e           state, state_nxt;
  logic [WORDS_W-1:0]  words_left, left_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [7:0]          len_nxt;
  logic                req_nxt;
  // A frame_start that lands while a burst is on the bus is remembered here
  // and acted on once that burst completes.
  logic                restart_pend, pend_nxt;
  logic                pend_sel, psel_nxt;

  function automatic logic [ADDR_W-1:0] base_of(input logic sel);
    return sel ? BASE1 : BASE0;
  endfunction

  always_comb begin
    state_nxt = state;
    addr_nxt  = rd_addr;
    len_nxt   = rd_len;
    req_nxt   = rd_req;
    left_nxt  = words_left;
    pend_nxt  = restart_pend;
    psel_nxt  = pend_sel;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (frame_start) begin
          state_nxt = ST_FLUSH;
          addr_nxt  = base_of(frame_sel);
          left_nxt  = FRAME_W;
        end
      end
      ST_FLUSH: begin
        // frame_start here is deliberately ignored: the flush is already happening.
        state_nxt = ST_WAIT_ROOM;
      end
      ST_WAIT_ROOM: begin
        if (frame_start) begin
          state_nxt = ST_FLUSH;
          addr_nxt  = base_of(frame_sel);
          left_nxt  = FRAME_W;
        end else if (fifo_wr_cnt <= ROOM_LVL) begin
          state_nxt = ST_REQ;
          req_nxt   = 1'b1;
          // Last burst of a frame carries the remainder.
          len_nxt   = (words_left < BURST_W) ? words_left[7:0] : BURST_W[7:0];
        end
      end
      ST_REQ: begin
        if (rd_ack) begin
          // Arbiter already captured the burst, so ack beats a same-cycle restart.
          req_nxt   = 1'b0;
          state_nxt = ST_XFER;
          if (frame_start) begin
            pend_nxt = 1'b1;
            psel_nxt = frame_sel;
          end
        end else if (frame_start) begin
          req_nxt   = 1'b0;
          state_nxt = ST_FLUSH;
          addr_nxt  = base_of(frame_sel);
          left_nxt  = FRAME_W;
        end
      end
      ST_XFER: begin
        if (frame_start) begin
          pend_nxt = 1'b1;
          psel_nxt = frame_sel;
        end
        if (rd_done) begin
          if (restart_pend || frame_start) begin
            state_nxt = ST_FLUSH;
            addr_nxt  = base_of(frame_start ? frame_sel : pend_sel);
            left_nxt  = FRAME_W;
            pend_nxt  = 1'b0;
          end else begin
            addr_nxt  = rd_addr + ADDR_W'(rd_len);
            left_nxt  = words_left - WORDS_W'(rd_len);
            state_nxt = (words_left == WORDS_W'(rd_len)) ? ST_DONE : ST_WAIT_ROOM;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      rd_len       <= '0;
      fifo_clr     <= 1'b0;
      busy         <= 1'b0;
      underflow    <= 1'b0;
      words_left   <= '0;
      restart_pend <= 1'b0;
      pend_sel     <= 1'b0;
    end else begin
      state        <= state_nxt;
      rd_req       <= req_nxt;
      rd_addr      <= addr_nxt;
      rd_len       <= len_nxt;
      words_left   <= left_nxt;
      restart_pend <= pend_nxt;
      pend_sel     <= psel_nxt;
      fifo_clr     <= (state_nxt == ST_FLUSH);
      busy         <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      // Clear wins over a same-cycle underflow: the FIFO is being flushed anyway.
      if (state == ST_FLUSH)
        underflow <= 1'b0;
      else if (pix_data_req && fifo_empty)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_frame_rd_sched.sv
// Self-checking bench: small-frame instance (100x1) for vectors, corner cases and
// randomized arbiter/FIFO traffic against a burst-level model; default instance
// for one complete 640x480 frame.
module tb_vga_frame_rd_sched;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // small-frame instance
  logic        b_rst, b_fs, b_sel, b_empty, b_pix, b_ack, b_done;
  logic [10:0] b_cnt;
  logic        b_clr, b_req, b_busy, b_uf;
  logic [27:0] b_addr;
  logic [7:0]  b_len;

  // full-frame instance
  logic        a_rst, a_fs, a_sel, a_empty, a_pix, a_ack, a_done;
  logic [10:0] a_cnt;
  logic        a_clr, a_req, a_busy, a_uf;
  logic [27:0] a_addr;
  logic [7:0]  a_len;

  vga_frame_rd_sched #(.H_ACTIVE(100), .V_ACTIVE(1)) dut_b (
    .vga_clk(vga_clk), .sys_rst(b_rst), .frame_start(b_fs), .frame_sel(b_sel),
    .fifo_wr_cnt(b_cnt), .fifo_empty(b_empty), .pix_data_req(b_pix),
    .fifo_clr(b_clr), .rd_req(b_req), .rd_addr(b_addr), .rd_len(b_len),
    .rd_ack(b_ack), .rd_done(b_done), .busy(b_busy), .underflow(b_uf)
  );

  vga_frame_rd_sched dut_a (
    .vga_clk(vga_clk), .sys_rst(a_rst), .frame_start(a_fs), .frame_sel(a_sel),
    .fifo_wr_cnt(a_cnt), .fifo_empty(a_empty), .pix_data_req(a_pix),
    .fifo_clr(a_clr), .rd_req(a_req), .rd_addr(a_addr), .rd_len(a_len),
    .rd_ack(a_ack), .rd_done(a_done), .busy(a_busy), .underflow(a_uf)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic wait_b_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (b_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // One record per clock: inputs driven, then outputs expected after that edge.
  typedef struct packed {
    logic        rst;
    logic        fs;
    logic        sel;
    logic [10:0] cnt;
    logic        ue;     // pix_data_req and fifo_empty together
    logic        ack;
    logic        done;
    logic        e_clr;
    logic        e_req;
    logic [27:0] e_addr;
    logic [7:0]  e_len;
    logic        e_busy;
    logic        e_uf;
  } vec_t;

  vec_t tbl [31];

  initial begin
    bit          ok;
    int          k, rem, ack_dly, done_dly, n, bad, exp_len;
    bit          outst, pend_sel, exp_uf, fs_since_clr, chk_idle, timeout;
    bit          prev_req, prev_clr;
    logic [10:0] prev_cnt;
    logic [27:0] prev_addr, base, last_addr;
    logic [7:0]  prev_len;

    b_rst = 1; b_fs = 0; b_sel = 0; b_cnt = 0; b_empty = 0; b_pix = 0; b_ack = 0; b_done = 0;
    a_rst = 1; a_fs = 0; a_sel = 0; a_cnt = 0; a_empty = 0; a_pix = 0; a_ack = 0; a_done = 0;

    //           rst fs sel cnt         ue ack dn  clr req addr          len    busy uf
    tbl[0]  = '{1, 0, 0, 11'd0,    0, 0, 0,  0, 0, 28'h0,       8'd0,  0, 0};
    tbl[1]  = '{1, 0, 0, 11'd0,    0, 0, 0,  0, 0, 28'h0,       8'd0,  0, 0};
    tbl[2]  = '{1, 0, 0, 11'd0,    0, 0, 0,  0, 0, 28'h0,       8'd0,  0, 0};
    tbl[3]  = '{0, 0, 0, 11'd0,    0, 0, 0,  0, 0, 28'h0,       8'd0,  0, 0};
    tbl[4]  = '{0, 1, 0, 11'd961,  0, 0, 0,  1, 0, 28'h0,       8'd0,  1, 0};
    tbl[5]  = '{0, 0, 0, 11'd961,  0, 0, 0,  0, 0, 28'h0,       8'd0,  1, 0};
    tbl[6]  = '{0, 0, 0, 11'd961,  0, 0, 0,  0, 0, 28'h0,       8'd0,  1, 0};
    tbl[7]  = '{0, 0, 0, 11'd960,  0, 0, 0,  0, 1, 28'h0,       8'd64, 1, 0};
    tbl[8]  = '{0, 0, 0, 11'd960,  0, 0, 0,  0, 1, 28'h0,       8'd64, 1, 0};
    tbl[9]  = '{0, 0, 0, 11'd960,  0, 1, 0,  0, 0, 28'h0,       8'd64, 1, 0};
    tbl[10] = '{0, 0, 0, 11'd960,  0, 1, 0,  0, 0, 28'h0,       8'd64, 1, 0};
    tbl[11] = '{0, 0, 0, 11'd0,    0, 0, 1,  0, 0, 28'd64,      8'd64, 1, 0};
    tbl[12] = '{0, 0, 0, 11'd0,    0, 0, 0,  0, 1, 28'd64,      8'd36, 1, 0};
    tbl[13] = '{0, 0, 0, 11'd0,    0, 1, 0,  0, 0, 28'd64,      8'd36, 1, 0};
    tbl[14] = '{0, 0, 0, 11'd0,    1, 0, 0,  0, 0, 28'd64,      8'd36, 1, 1};
    tbl[15] = '{0, 0, 0, 11'd0,    0, 0, 1,  0, 0, 28'd100,     8'd36, 0, 1};
    tbl[16] = '{0, 0, 0, 11'd0,    0, 0, 1,  0, 0, 28'd100,     8'd36, 0, 1};
    tbl[17] = '{0, 1, 1, 11'd0,    0, 0, 0,  1, 0, 28'h080000,  8'd36, 1, 1};
    tbl[18] = '{0, 0, 0, 11'd1000, 0, 0, 0,  0, 0, 28'h080000,  8'd36, 1, 0};
    tbl[19] = '{0, 1, 0, 11'd1000, 0, 0, 0,  1, 0, 28'h0,       8'd36, 1, 0};
    tbl[20] = '{0, 1, 1, 11'd0,    0, 0, 0,  0, 0, 28'h0,       8'd36, 1, 0};
    tbl[21] = '{0, 0, 0, 11'd0,    0, 0, 0,  0, 1, 28'h0,       8'd64, 1, 0};
    tbl[22] = '{0, 1, 1, 11'd0,    0, 0, 0,  1, 0, 28'h080000,  8'd64, 1, 0};
    tbl[23] = '{0, 0, 0, 11'd0,    0, 0, 0,  0, 0, 28'h080000,  8'd64, 1, 0};
    tbl[24] = '{0, 0, 0, 11'd0,    0, 0, 0,  0, 1, 28'h080000,  8'd64, 1, 0};
    tbl[25] = '{0, 1, 0, 11'd0,    0, 1, 0,  0, 0, 28'h080000,  8'd64, 1, 0};
    tbl[26] = '{0, 0, 0, 11'd0,    0, 0, 0,  0, 0, 28'h080000,  8'd64, 1, 0};
    tbl[27] = '{0, 0, 0, 11'd0,    0, 0, 1,  1, 0, 28'h0,       8'd64, 1, 0};
    tbl[28] = '{0, 0, 0, 11'd0,    0, 0, 0,  0, 0, 28'h0,       8'd64, 1, 0};
    tbl[29] = '{0, 0, 0, 11'd0,    0, 0, 0,  0, 1, 28'h0,       8'd64, 1, 0};
    tbl[30] = '{1, 0, 0, 11'd0,    0, 0, 0,  0, 0, 28'h0,       8'd0,  0, 0};

    step();
    for (int i = 0; i < 31; i++) begin
      b_rst = tbl[i].rst; b_fs = tbl[i].fs; b_sel = tbl[i].sel; b_cnt = tbl[i].cnt;
      b_pix = tbl[i].ue;  b_empty = tbl[i].ue; b_ack = tbl[i].ack; b_done = tbl[i].done;
      step();
      chk($sformatf("v%0d fifo_clr", i),  32'(b_clr),  32'(tbl[i].e_clr));
      chk($sformatf("v%0d rd_req", i),    32'(b_req),  32'(tbl[i].e_req));
      chk($sformatf("v%0d rd_addr", i),   32'(b_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d rd_len", i),    32'(b_len),  32'(tbl[i].e_len));
      chk($sformatf("v%0d busy", i),      32'(b_busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d underflow", i), 32'(b_uf),   32'(tbl[i].e_uf));
    end

    // frame_start during XFER: flush deferred until rd_done, new buffer used.
    b_rst = 1; b_fs = 0; b_ack = 0; b_done = 0; b_pix = 0; b_empty = 0; b_cnt = 0;
    step();
    b_rst = 0; b_sel = 0; b_fs = 1;
    step();
    b_fs = 0;
    wait_b_req(ok);
    chk("xfer_restart first req", 32'(ok), 32'd1);
    b_ack = 1;
    step();
    b_ack = 0; b_fs = 1; b_sel = 1;
    step();
    b_fs = 0; b_sel = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("xfer_restart no clr %0d", i), 32'(b_clr), 32'd0);
      step();
    end
    b_done = 1;
    step();
    b_done = 0;
    chk("xfer_restart clr after done", 32'(b_clr), 32'd1);
    step();
    chk("xfer_restart clr one cycle", 32'(b_clr), 32'd0);
    wait_b_req(ok);
    chk("xfer_restart second req", 32'(ok), 32'd1);
    chk("xfer_restart addr", 32'(b_addr), 32'h0008_0000);
    chk("xfer_restart len", 32'(b_len), 32'd64);

    // Randomized traffic: bench acts as arbiter; model predicts each accepted burst.
    b_rst = 1; b_fs = 0; b_ack = 0; b_done = 0;
    step();
    b_rst = 0;
    k = 0; base = 0; pend_sel = 0; exp_uf = 0; fs_since_clr = 0; chk_idle = 0;
    outst = 0; done_dly = 0; ack_dly = int'($urandom_range(0, 3));
    prev_req = 0; prev_clr = 0; prev_cnt = 0; prev_addr = 0; prev_len = 0;
    for (int c = 0; c < 4000; c++) begin
      chk("rnd underflow", 32'(b_uf), 32'(exp_uf));
      if (chk_idle) begin
        chk("rnd frame end busy", 32'(b_busy), 32'd0);
        chk("rnd frame end req", 32'(b_req), 32'd0);
        chk_idle = 0;
      end
      if (b_req && !prev_req)
        chk("rnd room before req", 32'(prev_cnt <= 11'd960), 32'd1);
      if (b_req && prev_req) begin
        chk("rnd addr stable", 32'(b_addr), 32'(prev_addr));
        chk("rnd len stable", 32'(b_len), 32'(prev_len));
      end
      if (b_clr) begin
        chk("rnd clr width", 32'(prev_clr), 32'd0);
        k = 0;
        base = pend_sel ? 28'h080000 : 28'h0;
        fs_since_clr = 0;
      end

      b_ack = 0; b_done = 0; b_fs = 0;
      if (outst) begin
        if (done_dly == 0) begin
          b_done = 1;
          outst = 0;
        end else done_dly--;
      end else if (b_req) begin
        if (ack_dly == 0) begin
          b_ack = 1;
          chk("rnd burst within frame", 32'(k < 2), 32'd1);
          if (k < 2) begin
            rem = 100 - 64 * k;
            exp_len = (rem > 64) ? 64 : rem;
            chk("rnd burst addr", 32'(b_addr), 32'(base + 28'(64 * k)));
            chk("rnd burst len", 32'(b_len), 32'(exp_len));
          end
          k++;
          outst = 1;
          done_dly = int'($urandom_range(0, 5));
          ack_dly  = int'($urandom_range(0, 3));
        end else ack_dly--;
      end
      if (!b_clr && $urandom_range(0, 39) == 0) begin
        b_fs = 1;
        b_sel = 1'($urandom_range(0, 1));
        pend_sel = b_sel;
        fs_since_clr = 1;
      end
      if (b_done && k == 2 && !fs_since_clr) chk_idle = 1;
      b_pix   = 1'($urandom_range(0, 1));
      b_empty = !b_clr && ($urandom_range(0, 29) == 0);
      b_cnt   = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(940, 980))
                                            : 11'($urandom_range(0, 1023));
      exp_uf    = b_clr ? 1'b0 : (exp_uf | (b_pix & b_empty));
      prev_req  = b_req;  prev_clr = b_clr; prev_cnt = b_cnt;
      prev_addr = b_addr; prev_len = b_len;
      step();
    end

    // One complete default-size frame with a fast arbiter.
    b_ack = 0; b_done = 0; b_fs = 0; b_pix = 0; b_empty = 0;
    step();
    a_rst = 0;
    step();
    chk("full idle busy", 32'(a_busy), 32'd0);
    a_fs = 1; a_sel = 0;
    step();
    a_fs = 0;
    n = 0; bad = 0; outst = 0; timeout = 1; last_addr = 0;
    for (int c = 0; c < 40000; c++) begin
      a_ack = 0; a_done = 0;
      if (outst) begin
        a_done = 1;
        outst = 0;
      end else if (a_req) begin
        a_ack = 1;
        if (a_addr != 28'(64 * n) || a_len != 8'd64) bad++;
        last_addr = a_addr;
        n++;
        outst = 1;
      end else if (!a_busy && n > 0) begin
        timeout = 0;
        break;
      end
      step();
    end
    a_ack = 0; a_done = 0;
    chk("full finished in budget", 32'(timeout), 32'd0);
    chk("full burst count", 32'(n), 32'd4800);
    chk("full bad bursts", 32'(bad), 32'd0);
    chk("full last addr", 32'(last_addr), 32'h0004_AFC0);
    chk("full busy after", 32'(a_busy), 32'd0);
    chk("full underflow", 32'(a_uf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
